// File: rtl/cc_port_hub.sv
// Port hub between the soft-processor port bus and the scratch registers, board I/O,
// UART FIFO strobes and a maskable, acknowledged interrupt controller.
module cc_port_hub #(
  parameter int NUM_REGS = 8,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16,
  parameter int BTN_W    = 8,
  parameter int EXT_IRQ  = 2,
  parameter int TICK_DIV = 100000000,
  localparam int EXT_W   = (EXT_IRQ > 0) ? EXT_IRQ : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [LED_W-1:0] led,
  input  logic [BTN_W-1:0] button,
  input  logic [SW_W-1:0]  switch,
  input  logic [EXT_W-1:0] irq_ext,
  output logic             interrupt,
  input  logic             interrupt_ack,
  input  logic [7:0]       port_id,
  input  logic [7:0]       port_out,
  output logic [7:0]       port_in,
  input  logic             write_strobe,
  input  logic             kwrite_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       data_out,
  input  logic             urx_buffer_full,
  input  logic             urx_buffer_half_full,
  input  logic             urx_buffer_data_present,
  output logic             urx_buffer_read,
  output logic [7:0]       data_in,
  input  logic             utx_buffer_full,
  input  logic             utx_buffer_half_full,
  input  logic             utx_buffer_data_present,
  output logic             utx_buffer_write
);

  localparam int NSRC = 3 + EXT_IRQ;
  localparam logic [7:0] SRC_MASK = 8'((1 << NSRC) - 1);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;

  logic [7:0]       regs [NUM_REGS];
  logic [7:0]       mask, pending, evt, active, cause, rd_data, w1c_bits;
  logic [2:0]       cause_idx;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_evt, wr, eoi, urx_present_d;
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [BTN_W-1:0] btn_s1, btn_s2, btn_d;
  logic [EXT_W-1:0] ext_s1, ext_s2, ext_d;
  irq_state_t       state, state_nxt;

  assign wr               = write_strobe | kwrite_strobe;
  assign eoi              = wr && (port_id == 8'h42);
  assign w1c_bits         = eoi ? port_out : 8'h00;
  assign utx_buffer_write = wr && (port_id == 8'h40);
  assign data_in          = port_out;
  assign tick_evt         = (tick_cnt == TICK_LAST);
  assign active           = pending & mask;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sw_s1, sw_s2}          <= '0;
      {btn_s1, btn_s2, btn_d} <= '0;
      {ext_s1, ext_s2, ext_d} <= '0;
      urx_present_d           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // so the chain really delays by one stage per clock.
      sw_s1         <= switch;
      sw_s2         <= sw_s1;
      btn_s1        <= button;
      btn_s2        <= btn_s1;
      btn_d         <= btn_s2;
      ext_s1        <= irq_ext;
      ext_s2        <= ext_s1;
      ext_d         <= ext_s2;
      urx_present_d <= urx_buffer_data_present;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    evt    = 8'h00;
    evt[0] = tick_evt;
    evt[1] = urx_buffer_data_present & ~urx_present_d;
    evt[2] = |(btn_s2 & ~btn_d);
    for (int i = 0; i < EXT_IRQ; i++) evt[3+i] = ext_s2[i] & ~ext_d[i];
  end

  always_comb begin
    cause_idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (active[i]) cause_idx = 3'(i);
    cause = (|active) ? {1'b1, 4'b0000, cause_idx} : 8'h00;
  end

  always_comb begin
    rd_data = 8'h00;
    for (int n = 0; n < NUM_REGS; n++) if (port_id == 8'(n)) rd_data = regs[n];
    case (port_id)
      8'h40:   rd_data = data_out;
      8'h41:   rd_data = {2'b00, urx_buffer_full, urx_buffer_half_full, urx_buffer_data_present,
                          utx_buffer_full, utx_buffer_half_full, utx_buffer_data_present};
      8'h42:   rd_data = pending;
      8'h43:   rd_data = mask;
      8'h44:   rd_data = cause;
      default: ;
    endcase
    for (int k = 0; k < SW_W / 8; k++)  if (port_id == 8'(8'h48 + k)) rd_data = sw_s2[8*k +: 8];
    for (int k = 0; k < BTN_W / 8; k++) if (port_id == 8'(8'h50 + k)) rd_data = btn_s2[8*k +: 8];
    for (int k = 0; k < LED_W / 8; k++) if (port_id == 8'(8'h58 + k)) rd_data = led[8*k +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the scratch file is explicitly cleared, so it maps to flops rather than RAM.
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= 8'h00;
      led             <= '0;
      mask            <= 8'h00;
      pending         <= 8'h00;
      tick_cnt        <= '0;
      port_in         <= 8'h00;
      urx_buffer_read <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_REGS; n++)
        if (wr && port_id == 8'(n)) regs[n] <= port_out;
      for (int k = 0; k < LED_W / 8; k++)
        if (wr && port_id == 8'(8'h58 + k)) led[8*k +: 8] <= port_out;
      if (wr && port_id == 8'h43) mask <= port_out & SRC_MASK;
      // Clear first, then OR in new events: a coincident event survives the W1C.
      pending         <= ((pending & ~w1c_bits) | evt) & SRC_MASK;
      tick_cnt        <= tick_evt ? '0 : tick_cnt + CNT_W'(1);
      port_in         <= rd_data;
      urx_buffer_read <= read_strobe && (port_id == 8'h40);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Once acknowledged, new requests stay parked until software writes EOI.
  always_comb begin
    state_nxt = state;
    interrupt = 1'b0;
    case (state)
      IDLE:    if (|active) state_nxt = REQ;
      REQ: begin
        interrupt = 1'b1;
        if (interrupt_ack)  state_nxt = SERVICE;
        else if (!(|active)) state_nxt = IDLE;
      end
      SERVICE: if (eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cc_port_hub.sv
// Randomised and directed bench for cc_port_hub; a behavioural model queues expected
// read data and a negedge monitor compares it and the free-running outputs.
module tb_cc_port_hub;
  localparam int NUM_REGS = 8, LED_W = 16, SW_W = 16, BTN_W = 8, EXT_IRQ = 2, TICK_DIV = 10;
  localparam logic [7:0] SRC_MASK = 8'h1F;
  localparam int S_IDLE = 0, S_REQ = 1, S_SVC = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [LED_W-1:0] led;
  logic [BTN_W-1:0] button = '0;
  logic [SW_W-1:0]  switch = '0;
  logic [1:0]       irq_ext = '0;
  logic interrupt, interrupt_ack = 1'b0;
  logic [7:0] port_id = '0, port_out = '0, port_in, data_out = '0, data_in;
  logic write_strobe = 1'b0, kwrite_strobe = 1'b0, read_strobe = 1'b0;
  logic urx_buffer_full = 1'b0, urx_buffer_half_full = 1'b0, urx_buffer_data_present = 1'b0;
  logic utx_buffer_full = 1'b0, utx_buffer_half_full = 1'b0, utx_buffer_data_present = 1'b0;
  logic urx_buffer_read, utx_buffer_write;

  cc_port_hub #(.NUM_REGS(NUM_REGS), .LED_W(LED_W), .SW_W(SW_W), .BTN_W(BTN_W),
                .EXT_IRQ(EXT_IRQ), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .led(led), .button(button), .switch(switch),
    .irq_ext(irq_ext), .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .port_id(port_id), .port_out(port_out), .port_in(port_in),
    .write_strobe(write_strobe), .kwrite_strobe(kwrite_strobe), .read_strobe(read_strobe),
    .data_out(data_out), .urx_buffer_full(urx_buffer_full),
    .urx_buffer_half_full(urx_buffer_half_full),
    .urx_buffer_data_present(urx_buffer_data_present), .urx_buffer_read(urx_buffer_read),
    .data_in(data_in), .utx_buffer_full(utx_buffer_full),
    .utx_buffer_half_full(utx_buffer_half_full),
    .utx_buffer_data_present(utx_buffer_data_present), .utx_buffer_write(utx_buffer_write));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [7:0] id; logic [7:0] val; } rd_exp_t;
  rd_exp_t exp_q[$];

  logic [7:0]       m_regs [NUM_REGS];
  logic [LED_W-1:0] m_led;
  logic [7:0]       m_mask, m_pend;
  logic [SW_W-1:0]  m_sw  [3];   // [0]: last sample, [1]: visible to reads, [2]: one older
  logic [BTN_W-1:0] m_btn [3];
  logic [1:0]       m_ext [3];
  logic             m_urx_prev, m_urx_rd;
  int               m_edges, m_ist;

  task automatic model_reset();
    for (int n = 0; n < NUM_REGS; n++) m_regs[n] = 8'h00;
    for (int j = 0; j < 3; j++) begin m_sw[j] = '0; m_btn[j] = '0; m_ext[j] = '0; end
    m_led = '0; m_mask = 8'h00; m_pend = 8'h00;
    m_urx_prev = 1'b0; m_urx_rd = 1'b0; m_edges = 0; m_ist = S_IDLE;
    exp_q.delete();
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] id);
    logic [7:0] v, act;
    v = 8'h00;
    act = m_pend & m_mask;
    if (id < NUM_REGS) v = m_regs[id[2:0]];
    else case (id)
      8'h40: v = data_out;
      8'h41: v = {2'b00, urx_buffer_full, urx_buffer_half_full, urx_buffer_data_present,
                  utx_buffer_full, utx_buffer_half_full, utx_buffer_data_present};
      8'h42: v = m_pend;
      8'h43: v = m_mask;
      8'h44: for (int i = 0; i < 8; i++) if (act[i]) begin v = 8'h80 | 8'(i); break; end
      8'h48: v = m_sw[1][7:0];
      8'h49: v = m_sw[1][15:8];
      8'h50: v = m_btn[1];
      8'h58: v = m_led[7:0];
      8'h59: v = m_led[15:8];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [7:0] evt, act;
    logic wr;
    wr = write_strobe | kwrite_strobe;
    if (read_strobe) exp_q.push_back('{port_id, model_read(port_id)});
    m_urx_rd = read_strobe && (port_id == 8'h40);
    act = m_pend & m_mask;
    evt = 8'h00;
    evt[0] = (m_edges % TICK_DIV) == TICK_DIV - 1;
    evt[1] = urx_buffer_data_present && !m_urx_prev;
    evt[2] = (m_btn[1] & ~m_btn[2]) != '0;
    evt[3] = m_ext[1][0] && !m_ext[2][0];
    evt[4] = m_ext[1][1] && !m_ext[2][1];
    case (m_ist)
      S_IDLE: if (act != 0) m_ist = S_REQ;
      S_REQ:  if (interrupt_ack) m_ist = S_SVC; else if (act == 0) m_ist = S_IDLE;
      default: if (wr && port_id == 8'h42) m_ist = S_IDLE;
    endcase
    if (wr) begin
      if (port_id < NUM_REGS) m_regs[port_id[2:0]] = port_out;
      if (port_id == 8'h58) m_led[7:0]  = port_out;
      if (port_id == 8'h59) m_led[15:8] = port_out;
      if (port_id == 8'h43) m_mask = port_out & SRC_MASK;
      if (port_id == 8'h42) m_pend = m_pend & ~port_out;
    end
    m_pend = (m_pend | evt) & SRC_MASK;
    m_sw[2] = m_sw[1];   m_sw[1] = m_sw[0];   m_sw[0] = switch;
    m_btn[2] = m_btn[1]; m_btn[1] = m_btn[0]; m_btn[0] = button;
    m_ext[2] = m_ext[1]; m_ext[1] = m_ext[0]; m_ext[0] = irq_ext;
    m_urx_prev = urx_buffer_data_present;
    m_edges++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("port_in[0x%02h]", e.id), 64'(port_in), 64'(e.val));
      end
      check("urx_buffer_read", 64'(urx_buffer_read), 64'(m_urx_rd));
      check("interrupt", 64'(interrupt), 64'(m_ist == S_REQ));
      check("led", 64'(led), 64'(m_led));
      check("utx_buffer_write", 64'(utx_buffer_write),
            64'((write_strobe | kwrite_strobe) && port_id == 8'h40));
      check("data_in", 64'(data_in), 64'(port_out));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge clk); #1; endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d, input logic k);
    if (k) kwrite_strobe = 1'b1; else write_strobe = 1'b1;
    port_id = id; port_out = d;
    cyc();
    write_strobe = 1'b0; kwrite_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] id);
    read_strobe = 1'b1; port_id = id;
    cyc();
    read_strobe = 1'b0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1; cyc(); interrupt_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; repeat (3) cyc(); reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    check("reset_port_in", 64'(port_in), 64'h00);
    check("reset_led", 64'(led), 64'h0);
    check("reset_interrupt", 64'(interrupt), 64'h0);
    rd(8'h42);
    check("reset_pending", 64'(port_in), 64'h00);

    // Register, LED and unmapped accesses
    switch = 16'h1234;
    wr(8'h03, 8'hA5, 1'b0);
    wr(8'h58, 8'h3C, 1'b1);
    wr(8'h59, 8'hC3, 1'b0);
    check("led_bytes", 64'(led), 64'hC33C);
    rd(8'h03); check("reg3", 64'(port_in), 64'hA5);
    rd(8'h5A); check("led_byte2", 64'(port_in), 64'h00);
    rd(8'h7F); check("unmapped", 64'(port_in), 64'h00);
    rd(8'h49); check("switch_hi", 64'(port_in), 64'h12);

    // UART strobes
    write_strobe = 1'b1; port_id = 8'h40; port_out = 8'h55; #1;
    check("tx_push", 64'(utx_buffer_write), 64'h1);
    check("tx_data", 64'(data_in), 64'h55);
    cyc(); write_strobe = 1'b0; #1;
    check("tx_push_end", 64'(utx_buffer_write), 64'h0);
    data_out = 8'h9E;
    rd(8'h40);
    check("rx_data", 64'(port_in), 64'h9E);
    check("rx_pop", 64'(urx_buffer_read), 64'h1);
    cyc();
    check("rx_pop_end", 64'(urx_buffer_read), 64'h0);

    // Tick interrupt, ack, hold-off until EOI
    do_reset();
    wr(8'h43, 8'h01, 1'b0);
    n = 1;
    while (interrupt !== 1'b1 && n < 40) begin cyc(); n++; end
    check("tick_irq_latency", 64'(n), 64'd11);
    ack();
    check("irq_after_ack", 64'(interrupt), 64'h0);
    repeat (25) cyc();
    check("irq_held_off", 64'(interrupt), 64'h0);
    rd(8'h42);
    check("tick_pending", 64'(port_in[0]), 64'h1);
    wr(8'h42, 8'h00, 1'b0);
    cyc();
    check("irq_after_eoi", 64'(interrupt), 64'h1);
    ack();
    wr(8'h42, 8'h01, 1'b0);

    // Masked button edge, then unmask
    wr(8'h43, 8'h00, 1'b0);
    wr(8'h42, 8'hFF, 1'b0);
    button = 8'h04;
    repeat (4) cyc();
    rd(8'h42); check("btn_pending", 64'(port_in & 8'hFE), 64'h04);
    rd(8'h44); check("cause_masked", 64'(port_in), 64'h00);
    wr(8'h43, 8'h04, 1'b0);
    cyc();
    check("irq_unmask", 64'(interrupt), 64'h1);
    rd(8'h44); check("cause_btn", 64'(port_in), 64'h82);

    // W1C coinciding with a UART-present rising edge
    ack();
    wr(8'h42, 8'h00, 1'b0);
    urx_buffer_data_present = 1'b1;
    wr(8'h42, 8'h02, 1'b0);
    rd(8'h42); check("w1c_vs_set", 64'(port_in[1]), 64'h1);

    // Asynchronous reset with an interrupt in flight
    if (interrupt) ack();
    wr(8'h42, 8'hFF, 1'b0);
    wr(8'h43, 8'h09, 1'b0);
    wr(8'h58, 8'h5A, 1'b0);
    irq_ext = 2'b01;
    n = 0;
    do begin rd(8'h42); n++; end
    while (!((port_in & 8'h1F) == 8'h09 && interrupt === 1'b1) && n < 40);
    check("pre_reset_pending", 64'(port_in & 8'h1F), 64'h09);
    check("pre_reset_irq", 64'(interrupt), 64'h1);
    rd(8'h40);
    #2 reset = 1'b1; irq_ext = 2'b00;
    #1;
    check("async_irq", 64'(interrupt), 64'h0);
    check("async_led", 64'(led), 64'h0);
    check("async_rx_pop", 64'(urx_buffer_read), 64'h0);
    check("async_port_in", 64'(port_in), 64'h00);
    repeat (2) cyc();
    reset = 1'b0;
    rd(8'h42); check("post_reset_pending", 64'(port_in), 64'h00);
    rd(8'h43); check("post_reset_mask", 64'(port_in), 64'h00);

    // Randomised traffic against the model
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 10))
        0: wr(8'($urandom_range(0, NUM_REGS)), 8'($urandom), 1'($urandom));
        1: rd(8'(8'h40 + $urandom_range(0, 4)));
        2: wr(8'(8'h58 + $urandom_range(0, 1)), 8'($urandom), 1'($urandom));
        3: wr(8'h43, 8'($urandom), 1'($urandom));
        4: wr(8'h42, 8'($urandom), 1'($urandom));
        5: begin switch = 16'($urandom); button = 8'($urandom); cyc(); end
        6: begin irq_ext = 2'($urandom); urx_buffer_data_present = 1'($urandom); cyc(); end
        7: begin
          data_out = 8'($urandom);
          {urx_buffer_full, urx_buffer_half_full} = 2'($urandom);
          {utx_buffer_full, utx_buffer_half_full, utx_buffer_data_present} = 3'($urandom);
          cyc();
        end
        8: if (interrupt) ack(); else cyc();
        9: rd(8'($urandom_range(0, 8'h5F)));
        default: wr(8'($urandom), 8'($urandom), 1'($urandom));
      endcase
    end
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
